noc_rotate_ctrl: RTL and testbench



---
 rtl/noc_ctrl_pkg.sv | 32 +++
 rtl/noc_gap_timer.sv | 28 ++
 rtl/noc_rotate_ctrl.sv | 138 +++++++++++++
 tb/tb_noc_rotate_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_ctrl_pkg.sv
// Shared definitions for the per-tile router rotate sequencer.
// State encoding, parameter defaults and pulse-vector bit positions.
package noc_ctrl_pkg;

  localparam int STEP_W_DEF = 4;
  localparam int GAP_DEF    = 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HROT  = 3'd2;
  localparam logic [2:0] S_VROT  = 3'd3;
  localparam logic [2:0] S_EXCH  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    LOAD     = S_LOAD,
    H_ROT    = S_HROT,
    V_ROT    = S_VROT,
    EXCH     = S_EXCH,
    GAP_WAIT = S_GAP,
    DONE     = S_DONE
  } state_t;

  localparam int PV_LOAD = 0;
  localparam int PV_H    = 1;
  localparam int PV_V    = 2;
  localparam int PV_X    = 3;
  localparam int PV_W    = 4;

endpackage

// File: rtl/noc_gap_timer.sv
// Loadable down-counter that times the router settle gap.
// zero is high once the count has run out.
module noc_gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/noc_rotate_ctrl.sv
// Sequencer driving one mesh router: inject, H/V rotations,
// optional exchange, each pulse followed by a settle gap.
module noc_rotate_ctrl
  import noc_ctrl_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int GAP    = GAP_DEF,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_h_steps,
  input  logic [STEP_W-1:0] cmd_v_steps,
  input  logic              cmd_exchange,
  input  logic              abort,
  output logic              ip_load,
  output logic              horizon_rotate,
  output logic              vertical_rotate,
  output logic              ip_router_exchange,
  output logic              busy,
  output logic              done
);

  localparam logic [GAP_W-1:0] GAP_LD =
    (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t            state;
  state_t            nxt;
  state_t            sel;
  logic [STEP_W-1:0] h_cnt;
  logic [STEP_W-1:0] v_cnt;
  logic              x_pend;
  logic              adv;
  logic              is_pulse;
  logic              gap_zero;
  logic [PV_W-1:0]   pv;

  assign is_pulse = (state == LOAD) || (state == H_ROT) ||
                    (state == V_ROT) || (state == EXCH);

  noc_gap_timer #(
    .W(GAP_W)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (is_pulse),
    .load_val (GAP_LD),
    .count    (state == GAP_WAIT),
    .zero     (gap_zero)
  );

  always_comb begin
    sel = DONE;
    if (h_cnt != '0) begin
      sel = H_ROT;
    end else if (v_cnt != '0) begin
      sel = V_ROT;
    end else if (x_pend) begin
      sel = EXCH;
    end
  end

  always_comb begin
    nxt = state;
    adv = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) nxt = LOAD;
      end
      LOAD, H_ROT, V_ROT, EXCH: begin
        if (GAP == 0) begin
          adv = 1'b1;
          nxt = sel;
        end else begin
          nxt = GAP_WAIT;
        end
      end
      GAP_WAIT: begin
        if (gap_zero) begin
          adv = 1'b1;
          nxt = sel;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort wins over any advance; IDLE ignores it
    if (abort && state != IDLE) begin
      nxt = IDLE;
      adv = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      h_cnt  <= '0;
      v_cnt  <= '0;
      x_pend <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && cmd_valid) begin
        h_cnt  <= cmd_h_steps;
        v_cnt  <= cmd_v_steps;
        x_pend <= cmd_exchange;
      end else if (adv) begin
        if (sel == H_ROT && h_cnt != '0)
          h_cnt <= h_cnt - STEP_W'(1);
        if (sel == V_ROT && v_cnt != '0)
          v_cnt <= v_cnt - STEP_W'(1);
        if (sel == EXCH)
          x_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    pv = '0;
    unique case (1'b1)
      (state == LOAD):  pv[PV_LOAD] = 1'b1;
      (state == H_ROT): pv[PV_H]    = 1'b1;
      (state == V_ROT): pv[PV_V]    = 1'b1;
      (state == EXCH):  pv[PV_X]    = 1'b1;
      default:          pv          = '0;
    endcase
  end

  assign ip_load            = pv[PV_LOAD];
  assign horizon_rotate     = pv[PV_H];
  assign vertical_rotate    = pv[PV_V];
  assign ip_router_exchange = pv[PV_X];
  assign cmd_ready          = (state == IDLE);
  assign busy               = (state != IDLE);
  assign done               = (state == DONE);

endmodule

// File: tb/tb_noc_rotate_ctrl.sv
// Bench for noc_rotate_ctrl: three instances (GAP 2, 0, 1)
// checked every cycle against a cycle-arithmetic model.
module tb_noc_rotate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid [3];
  logic       cmd_x     [3];
  logic       abort     [3];
  logic [3:0] cmd_h     [3];
  logic [3:0] cmd_v     [3];
  logic       rdy [3];
  logic       ld  [3];
  logic       hr  [3];
  logic       vr  [3];
  logic       xr  [3];
  logic       bsy [3];
  logic       dn  [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  bit m_act [3];
  int m_t [3];
  int m_h [3];
  int m_v [3];
  int m_x [3];

  int n_ld [3];
  int n_h  [3];
  int n_v  [3];
  int n_x  [3];
  int f_ld [3];
  int f_h  [3];
  int f_v  [3];
  int f_x  [3];
  int d_cyc [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    noc_rotate_ctrl #(
      .STEP_W (4),
      .GAP    (g == 0 ? 2 : (g == 1 ? 0 : 1)),
      .GAP_W  (4)
    ) u_dut (
      .clk                (clk),
      .rst                (rst),
      .cmd_valid          (cmd_valid[g]),
      .cmd_ready          (rdy[g]),
      .cmd_h_steps        (cmd_h[g]),
      .cmd_v_steps        (cmd_v[g]),
      .cmd_exchange       (cmd_x[g]),
      .abort              (abort[g]),
      .ip_load            (ld[g]),
      .horizon_rotate     (hr[g]),
      .vertical_rotate    (vr[g]),
      .ip_router_exchange (xr[g]),
      .busy               (bsy[g]),
      .done               (dn[g])
    );
  end

  function automatic int gap_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 1);
  endfunction

  function automatic int dlen(int i);
    int p;
    p = 1 + m_h[i] + m_v[i] + m_x[i];
    return p * (gap_of(i) + 1) + 1;
  endfunction

  // {load, h, v, x, busy, done, ready} for the current cycle
  function automatic logic [6:0] expv(int i);
    int gp;
    int k;
    logic [6:0] r;
    if (!m_act[i]) return 7'b0000001;
    if (m_t[i] == dlen(i)) return 7'b0000110;
    gp = gap_of(i) + 1;
    r = 7'b0000100;
    if ((m_t[i] - 1) % gp == 0) begin
      k = (m_t[i] - 1) / gp;
      if (k == 0) r[6] = 1'b1;
      else if (k <= m_h[i]) r[5] = 1'b1;
      else if (k <= m_h[i] + m_v[i]) r[4] = 1'b1;
      else r[3] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(string nm, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 0;
      end else if (!m_act[i]) begin
        if (cmd_valid[i]) begin
          m_act[i] = 1;
          m_t[i] = 1;
          m_h[i] = int'(cmd_h[i]);
          m_v[i] = int'(cmd_v[i]);
          m_x[i] = int'(cmd_x[i]);
        end
      end else if (abort[i] || m_t[i] == dlen(i)) begin
        m_act[i] = 0;
      end else begin
        m_t[i] = m_t[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [6:0] got;
        int np;
        got = {ld[i], hr[i], vr[i], xr[i], bsy[i], dn[i], rdy[i]};
        check($sformatf("out%0d_t%0d", i, m_t[i]), int'(got),
              int'(expv(i)));
        np = int'(ld[i]) + int'(hr[i]) + int'(vr[i]) + int'(xr[i]);
        check($sformatf("onehot%0d", i), int'(np <= 1), 1);
        if (m_act[i]) begin
          if (m_t[i] == 1) begin
            n_ld[i] = 0; n_h[i] = 0; n_v[i] = 0; n_x[i] = 0;
            f_ld[i] = -1; f_h[i] = -1; f_v[i] = -1; f_x[i] = -1;
            d_cyc[i] = -1;
          end
          if (ld[i]) begin
            n_ld[i]++;
            if (f_ld[i] < 0) f_ld[i] = m_t[i];
          end
          if (hr[i]) begin
            n_h[i]++;
            if (f_h[i] < 0) f_h[i] = m_t[i];
          end
          if (vr[i]) begin
            n_v[i]++;
            if (f_v[i] < 0) f_v[i] = m_t[i];
          end
          if (xr[i]) begin
            n_x[i]++;
            if (f_x[i] < 0) f_x[i] = m_t[i];
          end
          if (dn[i]) d_cyc[i] = m_t[i];
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(int i, int h, int v, int x);
    cmd_h[i] = 4'(h);
    cmd_v[i] = 4'(v);
    cmd_x[i] = x[0];
    cmd_valid[i] = 1'b1;
    @(posedge clk);
    tick();
    cmd_valid[i] = 1'b0;
    cmd_h[i] = 4'($urandom_range(15));
    cmd_v[i] = 4'($urandom_range(15));
    cmd_x[i] = 1'($urandom_range(1));
  endtask

  task automatic wait_done(int i, int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (dn[i]) begin
        ok = 1;
        break;
      end
      tick();
    end
    check($sformatf("done_seen%0d", i), int'(ok), 1);
  endtask

  task automatic wait_tm(int i, int t);
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (m_act[i] && m_t[i] == t) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("reach_cycle", int'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid[i] = 0; cmd_x[i] = 0; abort[i] = 0;
      cmd_h[i] = 0; cmd_v[i] = 0; m_act[i] = 0; m_t[i] = 0;
      m_h[i] = 0; m_v[i] = 0; m_x[i] = 0; d_cyc[i] = -1;
      n_ld[i] = 0; n_h[i] = 0; n_v[i] = 0; n_x[i] = 0;
      f_ld[i] = -1; f_h[i] = -1; f_v[i] = -1; f_x[i] = -1;
    end
    repeat (2) @(posedge clk);
    tick();
    rst = 1'b0;
    chk_en = 1;
    check("rst_ready", int'(rdy[0]), 1);
    check("rst_busy", int'(bsy[0]), 0);
    tick();

    issue(0, 1, 0, 1);
    wait_done(0, 40);
    check("t1_load", f_ld[0], 1);
    check("t1_h", f_h[0], 4);
    check("t1_x", f_x[0], 7);
    check("t1_done", d_cyc[0], 10);
    tick();
    check("t1_ready", int'(rdy[0]), 1);

    issue(1, 2, 2, 0);
    wait_done(1, 40);
    check("t2_done", d_cyc[1], 6);
    check("t2_fh", f_h[1], 2);
    check("t2_fv", f_v[1], 4);
    check("t2_nh", n_h[1], 2);
    check("t2_nv", n_v[1], 2);
    check("t2_nx", n_x[1], 0);
    tick();

    issue(0, 0, 0, 0);
    wait_done(0, 40);
    check("t3_done", d_cyc[0], 4);
    check("t3_nld", n_ld[0], 1);
    check("t3_nrot", n_h[0] + n_v[0] + n_x[0], 0);
    tick();

    issue(0, 3, 0, 0);
    wait_tm(0, 7);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("t4_ready", int'(rdy[0]), 1);
    check("t4_busy", int'(bsy[0]), 0);
    check("t4_nh", n_h[0], 2);
    check("t4_nodone", d_cyc[0], -1);
    tick();
    issue(0, 1, 1, 0);
    wait_done(0, 40);
    check("t4b_done", d_cyc[0], 10);
    check("t4b_nhv", n_h[0] * 10 + n_v[0], 11);
    tick();

    issue(0, 0, 15, 0);
    wait_tm(0, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ready", int'(rdy[0]), 1);
    check("t5_busy", int'(bsy[0]), 0);
    check("t5_vr", int'(vr[0]), 0);
    check("t5_nv", n_v[0], 2);
    check("t5_nodone", d_cyc[0], -1);
    tick();
    issue(0, 15, 15, 1);
    wait_done(0, 200);
    check("t5b_done", d_cyc[0], 97);
    check("t5b_nh", n_h[0], 15);
    check("t5b_nv", n_v[0], 15);
    check("t5b_nx", n_x[0], 1);
    tick();

    abort[1] = 1'b1;
    issue(1, 1, 0, 0);
    abort[1] = 1'b0;
    wait_done(1, 20);
    check("t6_done", d_cyc[1], 3);
    check("t6_nh", n_h[1], 1);
    tick();

    cmd_h[2] = 4'd1;
    cmd_v[2] = 4'd1;
    cmd_x[2] = 1'b0;
    cmd_valid[2] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_done(2, 30);
      check($sformatf("t7_done%0d", s), d_cyc[2], 7);
      check($sformatf("t7_cnt%0d", s),
            n_ld[2] * 100 + n_h[2] * 10 + n_v[2], 111);
      tick();
    end
    cmd_valid[2] = 1'b0;
    repeat (12) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
